// File: rtl/traffic_light_ctrl.sv
// Two-way traffic-light controller with a pedestrian phase, stepped by ticks
// derived from the rising edges of the divider's slow square wave.
module traffic_light_ctrl #(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 5,
    parameter int CNT_W        = 4
) (
    input  logic             clkIn,
    input  logic             rstN,
    input  logic             slowClk,
    input  logic             pedReq,
    output logic [2:0]       nsLight,
    output logic [2:0]       ewLight,
    output logic             pedWalk,
    output logic [CNT_W-1:0] remain,
    output logic             tickOut
);

    localparam logic [2:0] NS_GREEN  = 3'd0;
    localparam logic [2:0] NS_YELLOW = 3'd1;
    localparam logic [2:0] ALL_RED_1 = 3'd2;
    localparam logic [2:0] EW_GREEN  = 3'd3;
    localparam logic [2:0] EW_YELLOW = 3'd4;
    localparam logic [2:0] ALL_RED_2 = 3'd5;
    localparam logic [2:0] PED_WALK  = 3'd6;

    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LOAD   = CNT_W'(WALK_TICKS - 1);

    logic             s1, s2, s3;
    logic             tick;
    logic [2:0]       state, state_next;
    logic [CNT_W-1:0] remain_next;
    logic             ped_pending, ped_next;
    logic             phase_done;
    logic [2:0]       ns_next, ew_next;
    logic             walk_next;

    function automatic logic [CNT_W-1:0] dwell_load(input logic [2:0] st);
        case (st)
            NS_GREEN, EW_GREEN:   dwell_load = GREEN_LOAD;
            NS_YELLOW, EW_YELLOW: dwell_load = YELLOW_LOAD;
            PED_WALK:             dwell_load = WALK_LOAD;
            default:              dwell_load = ALLRED_LOAD;
        endcase
    endfunction

    assign tick       = s2 & ~s3;
    assign tickOut    = tick;
    assign phase_done = tick && (remain == '0);

    // NOTE: every output of a combinational block gets a default first, otherwise
    // any path that skips an assignment infers a latch.
    always_comb begin
        state_next  = state;
        remain_next = remain;
        if (phase_done) begin
            case (state)
                NS_GREEN:  state_next = NS_YELLOW;
                NS_YELLOW: state_next = ALL_RED_1;
                ALL_RED_1: state_next = EW_GREEN;
                EW_GREEN:  state_next = EW_YELLOW;
                EW_YELLOW: state_next = ALL_RED_2;
                ALL_RED_2: state_next = ped_pending ? PED_WALK : NS_GREEN;
                default:   state_next = NS_GREEN;
            endcase
            remain_next = dwell_load(state_next);
        end else if (tick) begin
            remain_next = remain - 1'b1;
        end
    end

    // Entering the walk phase clears the request even if the button is held.
    always_comb begin
        ped_next = ped_pending;
        if (phase_done && state == ALL_RED_2 && ped_pending)
            ped_next = 1'b0;
        else if (pedReq && state != PED_WALK)
            ped_next = 1'b1;
    end

    always_comb begin
        ns_next   = 3'b100;
        ew_next   = 3'b100;
        walk_next = 1'b0;
        case (state_next)
            NS_GREEN:  ns_next   = 3'b001;
            NS_YELLOW: ns_next   = 3'b010;
            EW_GREEN:  ew_next   = 3'b001;
            EW_YELLOW: ew_next   = 3'b010;
            PED_WALK:  walk_next = 1'b1;
            default:   ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, which keeps the s1->s2->s3 chain a true shift.
    always_ff @(posedge clkIn) begin
        if (!rstN) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            state       <= NS_GREEN;
            remain      <= GREEN_LOAD;
            ped_pending <= 1'b0;
            nsLight     <= 3'b001;
            ewLight     <= 3'b100;
            pedWalk     <= 1'b0;
        end else begin
            s1          <= slowClk;
            s2          <= s1;
            s3          <= s2;
            state       <= state_next;
            remain      <= remain_next;
            ped_pending <= ped_next;
            nsLight     <= ns_next;
            ewLight     <= ew_next;
            pedWalk     <= walk_next;
        end
    end

endmodule
